// File: rtl/arduino_cmd_rx.sv
// arduino_cmd_rx: 8N1 UART receiver that holds the last good command byte and falls back to IDLE_CMD when the link goes quiet
// Ports:
//   clk             system clock
//   rst             asynchronous active-high reset
//   uart_in         serial line from the Arduino, idle high, asynchronous to clk
//   arduino_command last good byte received, or IDLE_CMD after reset/timeout
//   cmd_valid       one-cycle pulse when arduino_command loads a good byte
//   frame_err       one-cycle pulse when a stop bit samples low
//   stale           no good byte within TIMEOUT_CLKS, or none since reset
//   busy            receiver is inside a frame or waiting out a break
module arduino_cmd_rx #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          TIMEOUT_CLKS = 25_000_000,
  parameter logic [7:0]  IDLE_CMD     = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_in,
  output logic [7:0] arduino_command,
  output logic       cmd_valid,
  output logic       frame_err,
  output logic       stale,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int WW = $clog2(TIMEOUT_CLKS);
  typedef enum logic [2:0] {S_ARM, S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
  state_t        r_state, w_state_nxt;
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic [WW-1:0] r_wd;
  logic          w_rx, w_bit_end, w_half, w_commit, w_ferr;
  assign w_rx      = r_sync[1];
  assign w_bit_end = r_cnt == CW'(CLKS_PER_BIT - 1);
  assign w_half    = r_cnt == CW'(CLKS_PER_BIT / 2 - 1);
  assign busy      = r_state inside {S_START, S_DATA, S_STOP, S_BREAK};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= S_ARM;
      r_sync  <= 2'b11;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sync  <= {r_sync[0], uart_in};
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  // ARM demands a full bit time of idle-high so a line held low across reset is not taken as a start bit.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_commit    = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      S_ARM: begin
        w_cnt_nxt   = (!w_rx || w_bit_end) ? '0 : r_cnt + CW'(1);
        w_state_nxt = (w_rx && w_bit_end) ? S_IDLE : S_ARM;
      end
      S_IDLE: begin
        w_cnt_nxt   = '0;
        w_bit_nxt   = '0;
        w_state_nxt = w_rx ? S_IDLE : S_START;
      end
      S_START:
        if (w_half) begin
          w_cnt_nxt   = '0;
          w_state_nxt = w_rx ? S_IDLE : S_DATA;
        end
      S_DATA:
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rx, r_shift[7:1]};
          w_bit_nxt   = r_bit + 3'd1;
          w_state_nxt = (r_bit == 3'd7) ? S_STOP : S_DATA;
        end
      S_STOP:
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_commit    = w_rx;
          w_ferr      = !w_rx;
          w_state_nxt = w_rx ? S_IDLE : S_BREAK;
        end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = w_rx ? S_ARM : S_BREAK;
      end
    endcase
  end
  // Timeout fires on the cycle the count would reach TIMEOUT_CLKS-1; a commit in that same cycle takes priority.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      arduino_command <= IDLE_CMD;
      cmd_valid       <= 1'b0;
      frame_err       <= 1'b0;
      stale           <= 1'b1;
      r_wd            <= '0;
    end else begin
      cmd_valid <= w_commit;
      frame_err <= w_ferr;
      if (w_commit) begin
        arduino_command <= r_shift;
        stale           <= 1'b0;
        r_wd            <= '0;
      end else if (!stale) begin
        if (r_wd == WW'(TIMEOUT_CLKS - 2)) begin
          arduino_command <= IDLE_CMD;
          stale           <= 1'b1;
          r_wd            <= '0;
        end else
          r_wd <= r_wd + WW'(1);
      end
    end
endmodule

// File: tb/tb_arduino_cmd_rx.sv
// tb_arduino_cmd_rx: table, hand-written and random frames checked against a frame-level scoreboard
module tb_arduino_cmd_rx;
  localparam int CPB = 16;
  localparam int TO  = 5000;
  localparam int LAT = CPB * 19 / 2;
  logic       clk, rst, uart_in;
  logic [7:0] arduino_command;
  logic       cmd_valid, frame_err, stale, busy;
  arduino_cmd_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO), .IDLE_CMD(8'h00)) dut (
    .clk(clk), .rst(rst), .uart_in(uart_in), .arduino_command(arduino_command),
    .cmd_valid(cmd_valid), .frame_err(frame_err), .stale(stale), .busy(busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct { logic [7:0] b; int fall; } exp_t;
  typedef struct { logic [7:0] data; bit stop_ok; int hold; int gap; logic [7:0] exp_cmd; int exp_ferr; bit exp_stale; } vec_t;
  exp_t       exp_q[$];
  int         ferr_q[$];
  int         n_vec = 0, n_bad = 0;
  int         cyc = 0, n_valid = 0, n_ferr = 0, last_valid_cyc = 0, since = 0;
  bit         exp_stale = 1'b1, old_es;
  logic [7:0] exp_cmd = 8'h00, prev_cmd;
  logic       prev_stale;
  exp_t       e;
  int         fc;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask
  task automatic lat_chk(input string nm, input int fall);
    n_vec++;
    if (cyc - fall < LAT || cyc - fall > LAT + 4) begin
      n_bad++;
      $display("FAIL %s: latency %0d cycles, expected %0d..%0d", nm, cyc - fall, LAT, LAT + 4);
    end
  endtask
  // Scoreboard: pulses are matched to frames in send order; stale/command follow the watchdog rules.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      exp_q.delete();
      ferr_q.delete();
      exp_stale = 1'b1;
      exp_cmd   = 8'h00;
      since     = 0;
    end else begin
      old_es = exp_stale;
      if (cmd_valid && frame_err) chk("valid_and_ferr", 1, 0);
      if (cmd_valid) begin
        n_valid++;
        last_valid_cyc = cyc;
        if (exp_q.size() == 0) chk("unexpected_cmd_valid", 1, 0);
        else begin
          e = exp_q.pop_front();
          lat_chk("cmd_valid_latency", e.fall);
          exp_cmd = e.b;
        end
        exp_stale = 1'b0;
        since     = 0;
      end else if (!exp_stale) begin
        since++;
        if (since == TO - 1) begin
          exp_stale = 1'b1;
          exp_cmd   = 8'h00;
        end
      end
      if (frame_err) begin
        n_ferr++;
        if (ferr_q.size() == 0) chk("unexpected_frame_err", 1, 0);
        else begin
          fc = ferr_q.pop_front();
          lat_chk("frame_err_latency", fc);
        end
      end
      if (cmd_valid || stale !== prev_stale || arduino_command !== prev_cmd || exp_stale != old_es) begin
        chk("stale", stale, exp_stale);
        chk("command", arduino_command, exp_cmd);
      end
    end
    prev_stale = stale;
    prev_cmd   = arduino_command;
  end
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] b, input bit stop_ok, input int hold, input int gap);
    if (stop_ok) exp_q.push_back('{b, cyc});
    else ferr_q.push_back(cyc);
    uart_in = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_in = b[i];
      wait_cyc(CPB);
      if (i == 4) chk("busy_data", busy, 1);
    end
    uart_in = stop_ok;
    wait_cyc(CPB);
    if (!stop_ok) begin
      wait_cyc(hold * CPB);
      chk("busy_break", busy, 1);
    end
    uart_in = 1'b1;
    wait_cyc(gap * CPB);
    if (gap > 0) chk("busy_idle", busy, 0);
  endtask
  task automatic chk_reset_vals();
    chk("rst_command", arduino_command, 8'h00);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_stale", stale, 1);
    chk("rst_busy", busy, 0);
  endtask
  initial begin
    #900_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    vec_t tbl[9];
    int   nf0, nv0, t0;
    logic [7:0] rb;
    bit   ok;
    int   hold, gap;
    tbl[0] = '{8'h57, 1, 0, 1, 8'h57, 0, 0};
    tbl[1] = '{8'h41, 1, 0, 0, 8'h41, 0, 0};
    tbl[2] = '{8'h53, 1, 0, 2, 8'h53, 0, 0};
    tbl[3] = '{8'h44, 0, 3, 2, 8'h53, 1, 0};
    tbl[4] = '{8'h64, 1, 0, 1, 8'h64, 0, 0};
    tbl[5] = '{8'h00, 1, 0, 0, 8'h00, 0, 0};
    tbl[6] = '{8'hFF, 1, 0, 0, 8'hFF, 0, 0};
    tbl[7] = '{8'h80, 0, 0, 2, 8'hFF, 1, 0};
    tbl[8] = '{8'h01, 1, 0, 1, 8'h01, 0, 0};
    rst = 1'b1;
    uart_in = 1'b1;
    wait_cyc(3);
    chk_reset_vals();
    rst = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 9; i++) begin
      nf0 = n_ferr;
      send(tbl[i].data, tbl[i].stop_ok, tbl[i].hold, tbl[i].gap);
      chk($sformatf("tbl%0d_command", i), arduino_command, tbl[i].exp_cmd);
      chk($sformatf("tbl%0d_ferr_count", i), n_ferr - nf0, tbl[i].exp_ferr);
      chk($sformatf("tbl%0d_stale", i), stale, tbl[i].exp_stale);
    end
    nv0 = n_valid;
    nf0 = n_ferr;
    uart_in = 1'b0;
    wait_cyc(CPB / 4);
    uart_in = 1'b1;
    wait_cyc(2 * CPB);
    chk("glitch_busy", busy, 0);
    chk("glitch_valid_count", n_valid - nv0, 0);
    chk("glitch_ferr_count", n_ferr - nf0, 0);
    chk("glitch_command", arduino_command, 8'h01);
    send(8'h77, 1, 0, 0);
    nv0 = n_valid;
    for (int k = 0; k < TO + 200 && !stale; k++) @(negedge clk);
    chk("timeout_stale", stale, 1);
    chk("timeout_delay", cyc - last_valid_cyc, TO - 1);
    chk("timeout_command", arduino_command, 8'h00);
    chk("timeout_no_valid", n_valid - nv0, 0);
    wait_cyc(CPB);
    send(8'h73, 1, 0, 1);
    chk("after_timeout_stale", stale, 0);
    chk("after_timeout_command", arduino_command, 8'h73);
    for (int i = 0; i < 30; i++) begin
      rb   = 8'($urandom);
      ok   = $urandom_range(0, 5) != 0;
      hold = ok ? 0 : $urandom_range(1, 3);
      gap  = ok ? $urandom_range(0, 2) : 2;
      if ($urandom_range(0, 9) == 0) gap = 350;
      send(rb, ok, hold, gap);
    end
    wait_cyc(CPB);
    uart_in = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 3; i++) begin
      uart_in = i[0];
      wait_cyc(CPB);
    end
    rst = 1'b1;
    uart_in = 1'b0;
    wait_cyc(2);
    chk_reset_vals();
    rst = 1'b0;
    nv0 = n_valid;
    nf0 = n_ferr;
    wait_cyc(2 * CPB);
    chk("held_low_busy", busy, 0);
    uart_in = 1'b1;
    wait_cyc(4);
    uart_in = 1'b0;
    wait_cyc(CPB / 2);
    chk("arm_busy_mid", busy, 0);
    wait_cyc(CPB / 2);
    chk("arm_busy_end", busy, 0);
    uart_in = 1'b1;
    wait_cyc(2 * CPB);
    chk("arm_no_valid", n_valid - nv0, 0);
    chk("arm_no_ferr", n_ferr - nf0, 0);
    t0 = n_valid;
    send(8'h20, 1, 0, 1);
    chk("post_reset_command", arduino_command, 8'h20);
    chk("post_reset_stale", stale, 0);
    chk("post_reset_valid_count", n_valid - t0, 1);
    chk("pending_cmd_frames", exp_q.size(), 0);
    chk("pending_err_frames", ferr_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
